// File: rtl/mem_stage.sv
// MEM pipeline stage: latches EXE results, extracts load data from the synchronous SRAM
// read port, and presents the write-back and forwarding buses to WB combinationally.
module mem_stage #(
  parameter int unsigned FWD_EN = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        EXE_to_MEM_valid,
  input  logic [73:0] EXE_MEM_reg,
  output logic        MEM_allow_in,
  input  logic [31:0] data_sram_rdata,
  input  logic        WB_allow_in,
  output logic        MEM_to_WB_valid,
  output logic [69:0] MEM_WB_reg,
  output logic [37:0] MEM_fwd_reg
);

  localparam logic [2:0] LdB  = 3'b001;
  localparam logic [2:0] LdH  = 3'b010;
  localparam logic [2:0] LdBu = 3'b011;
  localparam logic [2:0] LdHu = 3'b100;

  logic        mem_valid_q;
  logic        mem_first_q;
  logic [31:0] rdata_hold_q;

  logic [31:0] pc_q;
  logic        gr_we_q;
  logic [4:0]  dest_q;
  logic        res_from_mem_q;
  logic [2:0]  ld_op_q;
  logic [31:0] alu_result_q;

  logic        mem_ready_go;
  logic        accept;
  logic [31:0] rdata_eff;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign mem_ready_go    = 1'b1;
  assign MEM_allow_in    = !mem_valid_q || (mem_ready_go && WB_allow_in);
  assign MEM_to_WB_valid = mem_valid_q && mem_ready_go;
  assign accept          = EXE_to_MEM_valid && MEM_allow_in;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q  <= 1'b0;
      mem_first_q  <= 1'b0;
      rdata_hold_q <= 32'h0;
    end else begin
      if (MEM_allow_in) begin
        mem_valid_q <= EXE_to_MEM_valid;
      end
      mem_first_q <= accept;
      // SRAM data is only valid one cycle after the request; keep it for long WB stalls.
      if (mem_first_q) begin
        rdata_hold_q <= data_sram_rdata;
      end
    end
  end

  // Payload is don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      {pc_q, gr_we_q, dest_q, res_from_mem_q, ld_op_q, alu_result_q} <= EXE_MEM_reg;
    end
  end

  always_comb begin
    rdata_eff = mem_first_q ? data_sram_rdata : rdata_hold_q;

    unique case (alu_result_q[1:0])
      2'd0:    load_byte = rdata_eff[7:0];
      2'd1:    load_byte = rdata_eff[15:8];
      2'd2:    load_byte = rdata_eff[23:16];
      default: load_byte = rdata_eff[31:24];
    endcase

    // Bit 0 is ignored for halfwords; misalignment is not trapped here.
    load_half = alu_result_q[1] ? rdata_eff[31:16] : rdata_eff[15:0];

    case (ld_op_q)
      LdB:     load_data = {{24{load_byte[7]}}, load_byte};
      LdBu:    load_data = {24'h0, load_byte};
      LdH:     load_data = {{16{load_half[15]}}, load_half};
      LdHu:    load_data = {16'h0, load_half};
      default: load_data = rdata_eff;
    endcase

    final_result = res_from_mem_q ? load_data : alu_result_q;
  end

  assign MEM_WB_reg = {pc_q, gr_we_q, dest_q, final_result};

  if (FWD_EN != 0) begin : g_fwd
    assign MEM_fwd_reg = {gr_we_q && mem_valid_q && (dest_q != 5'd0), dest_q, final_result};
  end else begin : g_no_fwd
    assign MEM_fwd_reg = 38'h0;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random traffic against a
// transaction-level model of the stage.
module tb_mem_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic        rfm;
    logic [2:0]  ld_op;
    logic [31:0] alu;
  } instr_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exe_v;
  instr_t      exe_ins;
  logic        allow_in;
  logic [31:0] rdata;
  logic        wb_allow;
  logic        to_wb_valid;
  logic [69:0] wb_reg;
  logic [37:0] fwd_reg;

  int vectors = 0;
  int miscompares = 0;

  // Model: the instruction currently held, whether this is the cycle its SRAM word
  // arrives, and the word captured in that cycle.
  logic        m_valid;
  instr_t      m_ins;
  logic        m_arrival;
  logic [31:0] m_word;

  mem_stage #(.FWD_EN(1)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .EXE_to_MEM_valid (exe_v),
    .EXE_MEM_reg      (exe_ins),
    .MEM_allow_in     (allow_in),
    .data_sram_rdata  (rdata),
    .WB_allow_in      (wb_allow),
    .MEM_to_WB_valid  (to_wb_valid),
    .MEM_WB_reg       (wb_reg),
    .MEM_fwd_reg      (fwd_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] a,
                                          input logic [31:0] w);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] s;
    b = 8'((w >> (8 * int'(a))) & 32'hFF);
    h = 16'((w >> (16 * int'(a[1]))) & 32'hFFFF);
    case (op)
      3'd1:    begin s = $signed(b); return s; end
      3'd3:    return 32'(b);
      3'd2:    begin s = $signed(h); return s; end
      3'd4:    return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_result();
    logic [31:0] w;
    w = m_arrival ? rdata : m_word;
    return m_ins.rfm ? extract(m_ins.ld_op, m_ins.alu[1:0], w) : m_ins.alu;
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_arrival = 1'b0;
    m_word    = 32'h0;
  endtask

  task automatic check_outputs();
    logic [31:0] fin;
    check("allow_in", 70'(allow_in), 70'(!m_valid || wb_allow));
    check("to_wb_valid", 70'(to_wb_valid), 70'(m_valid));
    check("fwd_we", 70'(fwd_reg[37]), 70'(m_valid && m_ins.gr_we && m_ins.dest != 5'd0));
    if (m_valid) begin
      fin = model_result();
      check("wb_reg", wb_reg, {m_ins.pc, m_ins.gr_we, m_ins.dest, fin});
      check("fwd_bus", 70'(fwd_reg[36:0]), 70'({m_ins.dest, fin}));
    end
  endtask

  // Check the current cycle, then advance one clock and the model with it.
  task automatic step();
    logic acc;
    #1;
    check_outputs();
    @(posedge clk);
    acc = exe_v && (!m_valid || wb_allow);
    if (m_arrival) m_word = rdata;
    if (!m_valid || wb_allow) m_valid = exe_v;
    if (acc) m_ins = exe_ins;
    m_arrival = acc;
    #1;
  endtask

  task automatic drive(input logic v, input instr_t i, input logic wb, input logic [31:0] rd);
    exe_v    = v;
    exe_ins  = i;
    wb_allow = wb;
    rdata    = rd;
  endtask

  function automatic instr_t alu_i(input logic [4:0] dest, input logic [31:0] res);
    return '{pc: 32'h1c00_0000 + 32'(res[7:0]) * 4, gr_we: 1'b1, dest: dest, rfm: 1'b0,
             ld_op: 3'd0, alu: res};
  endfunction

  function automatic instr_t ld_i(input logic [2:0] op, input logic [31:0] addr);
    return '{pc: 32'h1c00_1000, gr_we: 1'b1, dest: 5'd9, rfm: 1'b1, ld_op: op, alu: addr};
  endfunction

  initial begin
    logic [2:0]  ops [5];
    logic [31:0] addrs [5];
    logic [31:0] wants [5];
    instr_t      r;

    ops   = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd0};
    addrs = '{32'h1002, 32'h1002, 32'h1002, 32'h1002, 32'h1000};
    wants = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};

    // Reset state
    resetn = 1'b0;
    drive(1'b0, '0, 1'b1, 32'h0);
    model_reset();
    m_ins = '0;
    #2;
    check("rst_valid", 70'(to_wb_valid), 70'(0));
    check("rst_allow", 70'(allow_in), 70'(1));
    check("rst_fwd_we", 70'(fwd_reg[37]), 70'(0));
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Back-to-back ALU results
    drive(1'b1, alu_i(5'd1, 32'h11), 1'b1, 32'h0);
    step();
    check("b2b_0", {to_wb_valid, wb_reg[31:0]}, {1'b1, 32'h11});
    drive(1'b1, alu_i(5'd2, 32'h22), 1'b1, 32'h0);
    step();
    check("b2b_1", {to_wb_valid, wb_reg[31:0]}, {1'b1, 32'h22});
    drive(1'b1, alu_i(5'd3, 32'h33), 1'b1, 32'h0);
    step();
    check("b2b_2", {to_wb_valid, wb_reg[31:0]}, {1'b1, 32'h33});
    drive(1'b0, '0, 1'b1, 32'h0);
    step();

    // Load extension; SRAM word arrives the cycle after accept
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, ld_i(ops[k], addrs[k]), 1'b1, 32'h0);
      step();
      drive(1'b0, '0, 1'b1, 32'h80FF_7F01);
      #1;
      check($sformatf("ld_ext_op%0d", ops[k]), 70'(wb_reg[31:0]), 70'(wants[k]));
      step();
    end

    // Stall hold with changing SRAM data
    drive(1'b1, ld_i(3'd0, 32'h2000), 1'b1, 32'h0);
    step();
    drive(1'b0, '0, 1'b0, 32'h1234_5678);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_result", 70'(wb_reg[31:0]), 70'(32'h1234_5678));
      check("stall_allow", 70'(allow_in), 70'(0));
      step();
      rdata = 32'hDEAD_BEEF;
    end
    #1;
    check("stall_end", 70'(wb_reg[31:0]), 70'(32'h1234_5678));
    wb_allow = 1'b1;
    step();

    // Forwarding
    drive(1'b1, alu_i(5'd0, 32'hABCD_0000), 1'b1, 32'h0);
    step();
    check("fwd_r0", 70'(fwd_reg[37]), 70'(0));
    drive(1'b1, alu_i(5'd5, 32'hCAFE_0005), 1'b1, 32'h0);
    step();
    check("fwd_r5", 70'(fwd_reg), 70'({1'b1, 5'd5, 32'hCAFE_0005}));
    drive(1'b0, '0, 1'b1, 32'h0);
    step();

    // Reset asserted between edges while stalled
    drive(1'b1, alu_i(5'd6, 32'h66), 1'b0, 32'h0);
    step();
    drive(1'b0, '0, 1'b0, 32'h0);
    step();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", 70'(to_wb_valid), 70'(0));
    check("mid_rst_allow", 70'(allow_in), 70'(1));
    @(posedge clk);
    #1 resetn = 1'b1;
    wb_allow = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_idle", 70'(to_wb_valid), 70'(0));
    end
    drive(1'b1, ld_i(3'd3, 32'h3001), 1'b1, 32'h0);
    step();
    drive(1'b0, '0, 1'b1, 32'h0000_A500);
    #1;
    check("post_rst_ld", 70'({to_wb_valid, wb_reg[31:0]}), 70'({1'b1, 32'h0000_00A5}));
    step();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      r = '{pc: $urandom, gr_we: 1'($urandom), dest: ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            rfm: 1'($urandom), ld_op: 3'($urandom), alu: $urandom};
      drive($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0, $urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: MEM_stage

Interface
REQ-001 SHALL have parameter FWD_EN, default 1, meaning: 1 drives the forward bus; 0 ties MEM_fwd_reg to zero.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port EXE_to_MEM_valid, input, 1: EXE holds a valid instruction for MEM.
REQ-005 SHALL have port EXE_MEM_reg, input, 74, with this layout: {pc[73:42], gr_we[41], dest[40:36], res_from_mem[35], ld_op[34:32], alu_result[31:0]}.
REQ-006 SHALL have port MEM_allow_in, output, 1: MEM accepts a new instruction this cycle.
REQ-007 SHALL have port data_sram_rdata, input, 32: synchronous read data; valid only in the first cycle after EXE issued the request.
REQ-008 SHALL have port WB_allow_in, input, 1: WB accepts an instruction.
REQ-009 SHALL have port MEM_to_WB_valid, output, 1.
REQ-010 SHALL have port MEM_WB_reg, output, 70, with this layout: {pc[69:38], gr_we[37], dest[36:32], final_result[31:0]}.
REQ-011 SHALL have port MEM_fwd_reg, output, 38, with this layout: {fwd_we[37], fwd_dest[36:32], fwd_data[31:0]}. This is the same format as the WB write-back bus.

Function
REQ-012 SHALL hold state: MEM_valid, the latched EXE_MEM_reg fields, first-cycle flag MEM_first, and a 32-bit rdata hold register.
REQ-013 SHALL set MEM_ready_go = 1.
REQ-014 SHALL compute MEM_allow_in = !MEM_valid || (MEM_ready_go && WB_allow_in).
REQ-015 SHALL compute MEM_to_WB_valid = MEM_valid && MEM_ready_go.
REQ-016 SHALL load MEM_valid <= EXE_to_MEM_valid on every edge where MEM_allow_in=1; otherwise MEM_valid holds.
REQ-017 SHALL latch the payload fields only when EXE_to_MEM_valid && MEM_allow_in; otherwise the payload holds.
REQ-018 SHALL set MEM_first <= 1 on each accept and clear it on any edge where no new instruction is accepted.
REQ-019 SHALL capture data_sram_rdata into the hold register on every edge where MEM_first=1; the hold register holds otherwise.
REQ-020 SHALL take effective read data = data_sram_rdata when MEM_first=1, and the hold register when MEM_first=0. Load data therefore survives arbitrary WB stalls.
REQ-021 SHALL extract load data by byte offset a = alu_result[1:0]:
- ld_op 000 (ld.w): full word.
- ld_op 001 (ld.b): byte a, sign-extended.
- ld_op 011 (ld.bu): byte a, zero-extended.
- ld_op 010 (ld.h): halfword alu_result[1], sign-extended.
- ld_op 100 (ld.hu): halfword alu_result[1], zero-extended.
- ld_op 101/110/111: treated as ld.w.
REQ-022 SHALL ignore alu_result[0] for halfword loads; no misalignment exception is raised.
REQ-023 SHALL set final_result = extracted load data when res_from_mem=1, else alu_result.
REQ-024 SHALL drive MEM_fwd_reg = {gr_we && MEM_valid && dest!=0, dest, final_result} when FWD_EN=1.
REQ-025 SHALL drive MEM_WB_reg and MEM_fwd_reg combinationally from the latched state. MEM adds zero cycles of latency; an instruction accepted at edge N is presented to WB during cycle N..N+1.
REQ-026 SHALL keep MEM_WB_reg and final_result stable throughout a stall (MEM_valid=1, WB_allow_in=0).
REQ-027 SHALL accept a new instruction on the same edge that the current one is taken by WB when WB_allow_in=1 and EXE_to_MEM_valid=1. This gives back-to-back throughput of one instruction per cycle.

Reset
REQ-028 SHALL, while resetn=0, asynchronously force MEM_valid=0, MEM_first=0, and the hold register=0. Outputs then read MEM_to_WB_valid=0, fwd_we=0, MEM_allow_in=1.
REQ-029 SHALL leave the payload registers unreset; they are don't-care while MEM_valid=0.
REQ-030 SHALL, on reset asserted mid-stall, drop the in-flight instruction with no write-back. After release, the first accept SHALL behave as from power-up.

Verification
REQ-031 Back-to-back: three ALU instructions with results 0x11, 0x22, 0x33 and WB_allow_in=1 -> MEM_to_WB_valid=1 on three consecutive cycles, carrying 0x11/0x22/0x33 in order.
REQ-032 Load extension: rdata=0x80FF7F01 with addr offset 2, for each load type:
- ld.b -> 0xFFFFFFFF
- ld.bu -> 0x000000FF
- ld.h -> 0xFFFF80FF
- ld.hu -> 0x000080FF
- ld.w at offset 0 -> 0x80FF7F01
REQ-033 Stall hold: ld.w accepted with rdata=0x12345678; WB_allow_in=0 for 3 cycles while rdata changes to 0xDEADBEEF -> final_result stays 0x12345678 throughout and MEM_allow_in=0 throughout.
REQ-034 Forwarding: ALU write to r0 with gr_we=1 -> fwd_we=0. Write to r5 -> MEM_fwd_reg = {1, 5, result}.
REQ-035 Reset mid-stall: resetn pulled low asynchronously between clock edges while MEM_valid=1 -> MEM_to_WB_valid=0 immediately, MEM_allow_in=1, and no stale write-back after release.
